lockin_readout_arbiter: RTL and testbench
=========================================

# lockin_readout_arbiter

Work-conserving round-robin arbiter that drains finished lock-in results (X, Y, freq) from up to LOCKIN_NUMBER lock-in channels into the 108-bit UDP acquisition FIFO. It sits between the lock-in channel array and the dual-clock UDP FIFO write port, in the clk_adc domain. It issues one-cycle read strobes back to the channels, tags each word with channel index and a sequence number, applies FIFO backpressure without loss, and counts stall cycles for diagnostics.

## Interface
- LOCKIN_NUMBER, 32: number of requesting lock-in channels, 2..256.
- clk_adc  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- lockin_output_valid  in  LOCKIN_NUMBER  per-channel result-ready level.
- X_flat  in  32*LOCKIN_NUMBER  channel i X at [32*i+31 : 32*i].
- Y_flat  in  32*LOCKIN_NUMBER  channel i Y, same packing.
- freq_flat  in  32*LOCKIN_NUMBER  channel i freq, same packing.
- udp_fifo_afull  in  1  FIFO almost-full; guarantees at least 2 free entries while low.
- stall_clear  in  1  one-cycle pulse; zeroes stall_count.
- lockin_output_read  out  LOCKIN_NUMBER  one-hot read strobe, 1 cycle.
- data_to_udp  out  108  {seq[3:0], ch[7:0], freq[31:0], Y[31:0], X[31:0]}.
- write_to_udp  out  1  FIFO write request, 1 cycle per word.
- stall_count  out  16  saturating count of backpressure cycles.

## Operation
- Request vector req = lockin_output_valid & ~mask.
- mask: bit of the channel granted at the previous edge; set for exactly one cycle, so a channel whose valid is still high the cycle after its strobe is not re-granted. All other bits 0.
- Grant condition at each edge: !udp_fifo_afull and req != 0.
- Winner: first set bit of req searching ptr, ptr+1, ..., LOCKIN_NUMBER-1, 0, ..., ptr-1.
- On grant: lockin_output_read <= one-hot(winner); write_to_udp <= 1; data_to_udp <= {seq, winner[7:0], freq_w, Y_w, X_w} sampled at that edge; seq <= seq+1 (4-bit wrap 15->0); ptr <= winner+1, wrapping LOCKIN_NUMBER-1 -> 0.
- No grant: lockin_output_read <= 0, write_to_udp <= 0, data_to_udp holds, ptr and seq hold.
- stall_count: +1 on each edge where udp_fifo_afull=1 and req != 0; saturates at 0xFFFF. stall_clear has priority over increment (result 0 that edge).
- No data is ever dropped; a pending channel simply waits.
- Channel contract: after observing its strobe, a channel deasserts valid within 1 cycle or presents a new result.

## Timing
- Reset (synchronous): lockin_output_read=0, write_to_udp=0, data_to_udp=0, stall_count=0, ptr=0, seq=0, mask=0. Reset mid-transfer aborts: outputs zero on the next edge, and a pending strobe is not emitted.
- Latency: valid sampled high at edge E (unmasked, afull low, winner) -> strobe, write_to_udp and data are valid for the cycle following E.
- Throughput: one word per cycle with multiple requesters. A single channel is granted at most every other cycle.
- udp_fifo_afull sampled at edge E gates the grant at E only. Headroom of 2 covers the registered write.
- Simultaneous valid on all channels: pure rotation order starting from ptr.
- stall_clear and reset arriving together: reset wins, with the same result.

## Test plan
- Reset: hold reset 3 cycles with all valids high -> all outputs 0; first grant after release goes to ch0, seq=0.
- N=4, only ch2 valid, held 3 cycles -> exactly one write: data ch=2, seq=0, X/Y/freq match inputs; lockin_output_read=4'b0100 for 1 cycle; no second grant in the masked cycle.
- N=4, all valid continuously (each channel re-asserts) -> grants 0,1,2,3,0,1 on consecutive cycles; seq 0..5.
- ptr=1 (after granting ch0), then valid on ch0 and ch3 only -> grant ch3, then ch0.
- udp_fifo_afull high 5 cycles with ch1 valid -> no writes, stall_count=5; on release, ch1 is written next edge. stall_clear -> 0. Forced 70000 stall cycles -> 0xFFFF.
- 17 consecutive grants -> seq 0..15 then 0. Reset asserted one cycle after a grant -> strobe and write drop to 0, and seq restarts at 0.

Source files
------------

// File: rtl/lockin_readout_arbiter.sv
// Round-robin readout arbiter: drains finished lock-in results into the UDP FIFO,
// tagging each word with channel index and a 4-bit sequence number.
module lockin_readout_arbiter #(
    parameter int unsigned LOCKIN_NUMBER = 32
) (
    input  logic                         clk_adc,
    input  logic                         reset,
    input  logic [LOCKIN_NUMBER-1:0]     lockin_output_valid,
    input  logic [32*LOCKIN_NUMBER-1:0]  X_flat,
    input  logic [32*LOCKIN_NUMBER-1:0]  Y_flat,
    input  logic [32*LOCKIN_NUMBER-1:0]  freq_flat,
    input  logic                         udp_fifo_afull,
    input  logic                         stall_clear,
    output logic [LOCKIN_NUMBER-1:0]     lockin_output_read,
    output logic [107:0]                 data_to_udp,
    output logic                         write_to_udp,
    output logic [15:0]                  stall_count
);

    localparam int unsigned PW = $clog2(LOCKIN_NUMBER);

    logic [LOCKIN_NUMBER-1:0] read_q, read_d;
    logic [107:0]             data_q, data_d;
    logic                     write_q, write_d;
    logic [15:0]              stall_q, stall_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [3:0]               seq_q, seq_d;

    logic [LOCKIN_NUMBER-1:0] req;
    logic [PW-1:0]            win;
    logic                     found;
    logic                     grant;
    int unsigned              idx;

    // The strobe register doubles as the one-cycle mask of last edge's winner.
    always_comb begin
        req   = lockin_output_valid & ~read_q;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < LOCKIN_NUMBER; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= LOCKIN_NUMBER) begin
                idx = idx - LOCKIN_NUMBER;
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
        grant = found & ~udp_fifo_afull;
    end

    always_comb begin
        read_d  = '0;
        write_d = 1'b0;
        data_d  = data_q;
        ptr_d   = ptr_q;
        seq_d   = seq_q;
        if (grant) begin
            read_d[win] = 1'b1;
            write_d     = 1'b1;
            data_d      = {seq_q, 8'(win),
                           freq_flat[32*win +: 32],
                           Y_flat[32*win +: 32],
                           X_flat[32*win +: 32]};
            seq_d       = seq_q + 4'd1;
            ptr_d       = (32'(win) == LOCKIN_NUMBER - 1) ? '0 : win + PW'(1);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (stall_clear) begin
            stall_d = '0;
        end else if (udp_fifo_afull && (|req) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            read_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            stall_q <= '0;
            ptr_q   <= '0;
            seq_q   <= '0;
        end else begin
            read_q  <= read_d;
            data_q  <= data_d;
            write_q <= write_d;
            stall_q <= stall_d;
            ptr_q   <= ptr_d;
            seq_q   <= seq_d;
        end
    end

    assign lockin_output_read = read_q;
    assign data_to_udp        = data_q;
    assign write_to_udp       = write_q;
    assign stall_count        = stall_q;

endmodule

// File: tb/tb_lockin_readout_arbiter.sv
// Directed bench for lockin_readout_arbiter (4 channels) with a behavioural
// round-robin model checked every cycle plus literal spot checks.
module tb_lockin_readout_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   valid;
    logic [32*N-1:0] xf, yf, ff;
    logic           afull;
    logic           sclr;
    logic [N-1:0]   rd;
    logic [107:0]   data;
    logic           wr;
    logic [15:0]    stall;

    logic [31:0] Xc [N];
    logic [31:0] Yc [N];
    logic [31:0] Fc [N];

    int vectors     = 0;
    int miscompares = 0;

    int           m_ptr, m_seq, m_last, m_stall;
    logic [N-1:0] e_read;
    logic         e_write;
    logic [107:0] e_data;

    always #5 clk = ~clk;

    lockin_readout_arbiter #(.LOCKIN_NUMBER(N)) dut (
        .clk_adc             (clk),
        .reset               (reset),
        .lockin_output_valid (valid),
        .X_flat              (xf),
        .Y_flat              (yf),
        .freq_flat           (ff),
        .udp_fifo_afull      (afull),
        .stall_clear         (sclr),
        .lockin_output_read  (rd),
        .data_to_udp         (data),
        .write_to_udp        (wr),
        .stall_count         (stall)
    );

    task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setdata(input int tag);
        for (int i = 0; i < N; i++) begin
            Xc[i] = 32'hA000_0000 + 32'(tag * 256 + i);
            Yc[i] = 32'hB000_0000 + 32'(tag * 256 + i * 3);
            Fc[i] = 32'hC000_0000 + 32'(tag * 256 + i * 7);
            xf[32*i +: 32] = Xc[i];
            yf[32*i +: 32] = Yc[i];
            ff[32*i +: 32] = Fc[i];
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: sees the same inputs as the DUT at each rising edge.
    always @(posedge clk) begin : model
        int  win;
        bit  any;
        if (reset) begin
            m_ptr = 0; m_seq = 0; m_last = -1; m_stall = 0;
            e_read = '0; e_write = 1'b0; e_data = '0;
        end else begin
            any = 0;
            win = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!any && valid[c] && c != m_last) begin
                    any = 1;
                    win = c;
                end
            end
            if (sclr) m_stall = 0;
            else if (afull && any) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (!afull && any) begin
                e_read  = '0;
                e_read[win] = 1'b1;
                e_write = 1'b1;
                e_data  = {4'(m_seq), 8'(win), Fc[win], Yc[win], Xc[win]};
                m_seq   = (m_seq + 1) % 16;
                m_ptr   = (win + 1) % N;
                m_last  = win;
            end else begin
                e_read  = '0;
                e_write = 1'b0;
                m_last  = -1;
            end
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("read",  108'(rd),    108'(e_read));
            check("write", 108'(wr),    108'(e_write));
            check("data",  data,        e_data);
            check("stall", 108'(stall), 108'(m_stall));
        end
    end

    initial begin : stim
        reset = 1'b1;
        valid = '1;
        afull = 1'b0;
        sclr  = 1'b0;
        setdata(0);

        // Reset held with all valids high
        step(3);
        check("rst_read",  108'(rd), 108'(0));
        check("rst_write", 108'(wr), 108'(0));
        check("rst_data",  data, 108'(0));
        check("rst_stall", 108'(stall), 108'(0));
        reset = 1'b0;
        step(1);
        check("first_read", 108'(rd), 108'(4'b0001));
        check("first_tag",  108'(data[107:96]), 108'(12'h000));
        valid = '0;
        step(1);

        // Single channel 2, honouring the deassert-within-one-cycle contract
        reset = 1'b1; step(1); reset = 1'b0;
        setdata(1);
        valid = 4'b0100;
        step(1);
        check("ch2_read",  108'(rd), 108'(4'b0100));
        check("ch2_write", 108'(wr), 108'(1));
        check("ch2_data",  data, {4'h0, 8'h02, Fc[2], Yc[2], Xc[2]});
        step(1);
        check("ch2_masked_write", 108'(wr), 108'(0));
        check("ch2_masked_read",  108'(rd), 108'(0));
        valid = '0;
        step(2);

        // Pointer at 1 after granting ch0: ch3 beats ch0
        reset = 1'b1; step(1); reset = 1'b0;
        valid = 4'b0001;
        step(1);
        check("ptr_ch0", 108'(rd), 108'(4'b0001));
        valid = '0;
        step(1);
        valid = 4'b1001;
        step(1);
        check("ptr_ch3", 108'(rd), 108'(4'b1000));
        check("ptr_ch3_tag", 108'(data[107:96]), 108'(12'h103));
        step(1);
        check("ptr_ch0b", 108'(rd), 108'(4'b0001));
        check("ptr_ch0b_tag", 108'(data[107:96]), 108'(12'h200));
        valid = '0;
        step(1);

        // Full rotation and sequence wrap over 17 grants
        reset = 1'b1; step(1); reset = 1'b0;
        setdata(2);
        valid = '1;
        for (int g = 0; g < 17; g++) begin
            step(1);
            check("rot_write", 108'(wr), 108'(1));
            check("rot_ch",    108'(data[103:96]), 108'(g % 4));
            check("rot_seq",   108'(data[107:104]), 108'(g % 16));
        end
        // Reset one cycle after a grant aborts everything
        reset = 1'b1;
        step(1);
        check("abort_write", 108'(wr), 108'(0));
        check("abort_read",  108'(rd), 108'(0));
        check("abort_data",  data, 108'(0));
        reset = 1'b0;
        step(1);
        check("restart_tag", 108'(data[107:96]), 108'(12'h000));
        check("restart_read", 108'(rd), 108'(4'b0001));
        valid = '0;
        step(1);

        // Backpressure and stall counter
        reset = 1'b1; step(1); reset = 1'b0;
        valid = 4'b0010;
        afull = 1'b1;
        step(5);
        check("stall5", 108'(stall), 108'(5));
        check("stall_nowrite", 108'(wr), 108'(0));
        afull = 1'b0;
        step(1);
        check("release_read", 108'(rd), 108'(4'b0010));
        check("release_tag",  108'(data[107:96]), 108'(12'h001));
        valid = '0;
        step(1);
        sclr = 1'b1;
        step(1);
        sclr = 1'b0;
        check("clear", 108'(stall), 108'(0));
        afull = 1'b1;
        valid = 4'b0010;
        sclr  = 1'b1;
        step(1);
        sclr = 1'b0;
        check("clear_priority", 108'(stall), 108'(0));
        step(2);
        check("stall2", 108'(stall), 108'(2));
        step(69998);
        check("saturate", 108'(stall), 108'(16'hFFFF));
        reset = 1'b1;
        sclr  = 1'b1;
        step(1);
        check("reset_and_clear", 108'(stall), 108'(0));
        reset = 1'b0;
        sclr  = 1'b0;
        afull = 1'b0;
        valid = '0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
